// File: rtl/shifter_pkg.sv
// Shared types and constants for the ALU shifter group.
package shifter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } sr_state_t;

    // Shift-type encoding, shared with the ALU decoder
    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/sr_iterative.sv
// Multi-cycle right shifter (srl/sra), one bit per clock, with valid/ready on both sides.
module sr_iterative
    import shifter_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    input  logic                 arith,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(N);

    sr_state_t       state_q;
    logic [N-1:0]    data_q;
    logic [CW-1:0]   count_q;
    logic            fill_q;
    logic            out_valid_q;
    logic            busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            count_q     <= '0;
            fill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q      <= in;
                        count_q     <= shamt;
                        fill_q      <= (arith == SHIFT_ARITH) & in[N-1];
                        busy_q      <= 1'b1;
                        out_valid_q <= (shamt == '0);
                        state_q     <= (shamt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data_q  <= {fill_q, data_q[N-1:1]};
                    count_q <= count_q - 1'b1;
                    // count==1 marks the final shift, so count never wraps below zero
                    if (count_q == CW'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Held low during reset so nothing is accepted while the block is being cleared
    assign in_ready  = (state_q == S_IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out       = data_q;

endmodule

// File: tb/tb_sr_iterative.sv
// Self-checking bench for sr_iterative: directed cases plus randomized operations.
module tb_sr_iterative;

    localparam int unsigned N  = 32;
    localparam int unsigned CW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in;
    logic [CW-1:0] shamt;
    logic          arith;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out;
    logic          busy;

    int nassert = 0;
    int nfail   = 0;

    sr_iterative #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .shamt     (shamt),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] v, input int s, input logic a);
        if (a) return N'($signed(v) >>> s);
        return v >> s;
    endfunction

    // Wait for in_ready, present operand for one accept cycle, then measure latency to out_valid.
    task automatic start_and_wait(input logic [N-1:0] v, input int s, input logic a,
                                  input string tag, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        check({tag, "_ready"}, N'(in_ready), N'(1));
        in_valid = 1'b1;
        in       = v;
        shamt    = CW'(s);
        arith    = a;
        tick();
        in_valid = 1'b0;
        in       = $urandom;
        shamt    = CW'($urandom);
        arith    = ~a;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, N'(lat), N'(s + 1));
        check({tag, "_out"}, out, model(v, s, a));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ovfall"}, N'(out_valid), N'(0));
        check({tag, "_idle"}, N'(in_ready), N'(1));
    endtask

    initial begin
        int lat;
        logic [N-1:0] held;
        logic [N-1:0] v;
        int s;
        logic a;

        rst = 1'b1; in_valid = 1'b0; in = '0; shamt = '0; arith = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_out", out, '0);
        check("rst_ovalid", N'(out_valid), N'(0));
        check("rst_busy", N'(busy), N'(0));
        check("rst_inready", N'(in_ready), N'(0));
        rst = 1'b0;
        #1;
        check("post_rst_inready", N'(in_ready), N'(1));

        start_and_wait(32'hF000_0000, 4, 1'b0, "srl4", lat);
        drain("srl4");
        start_and_wait(32'h8000_0000, 31, 1'b1, "sra31", lat);
        check("sra31_val", out, 32'hFFFF_FFFF);
        drain("sra31");
        start_and_wait(32'h8000_0000, 31, 1'b0, "srl31", lat);
        check("srl31_val", out, 32'h0000_0001);
        drain("srl31");
        start_and_wait(32'hDEAD_BEEF, 0, 1'b1, "sh0", lat);
        check("sh0_val", out, 32'hDEAD_BEEF);

        // Backpressure: hold result while a new operand is offered
        held = out;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in = $urandom;
            shamt = CW'($urandom);
            tick();
            check("bp_out", out, held);
            check("bp_ovalid", N'(out_valid), N'(1));
            check("bp_inready", N'(in_ready), N'(0));
        end
        in_valid = 1'b0;
        drain("bp");

        // Reset in the middle of an operation
        start_and_wait(32'h1234_5678, 0, 1'b0, "pre", lat);
        drain("pre");
        in_valid = 1'b1; in = 32'hA5A5_A5A5; shamt = CW'(20); arith = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("mid_busy", N'(busy), N'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_inready", N'(in_ready), N'(0));
        tick();
        check("mid_rst_out", out, '0);
        check("mid_rst_ovalid", N'(out_valid), N'(0));
        check("mid_rst_busy", N'(busy), N'(0));
        rst = 1'b0;
        #1;
        check("mid_rst_ready", N'(in_ready), N'(1));
        lat = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) lat++;
        end
        check("mid_rst_noout", N'(lat), N'(0));

        // Back-to-back: next operand offered in the same cycle as the transfer
        start_and_wait(32'h0F0F_0000, 3, 1'b0, "b2b1", lat);
        v = $urandom; s = int'($urandom_range(1, 31)); a = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in = v; shamt = CW'(s); arith = a;
        #1;
        check("b2b_notaken", N'(in_ready), N'(0));
        tick();
        out_ready = 1'b0;
        check("b2b_idle_ready", N'(in_ready), N'(1));
        check("b2b_idle_ovalid", N'(out_valid), N'(0));
        tick();
        in_valid = 1'b0;
        check("b2b_accepted", N'(busy), N'(1));
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("b2b_lat", N'(lat), N'(s + 1));
        check("b2b_out", out, model(v, s, a));
        drain("b2b2");

        // Random operations with random backpressure
        for (int k = 0; k < 20; k++) begin
            v = $urandom;
            s = int'($urandom_range(0, 31));
            a = 1'(($urandom));
            start_and_wait(v, s, a, "rnd", lat);
            held = out;
            for (int j = int'($urandom_range(0, 3)); j > 0; j--) tick();
            check("rnd_hold", out, held);
            drain("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
